// File: rtl/ysyx_23060096_imem.sv
// ysyx_23060096_imem: instruction-memory responder for the fetch interface.
// It accepts one fetch request at a time and returns the 32-bit word at the
// requested PC after LATENCY clock edges.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request channel, req_addr is the byte PC
//   rsp_valid/rsp_ready      response channel, carrying rsp_inst and rsp_err
//   ld_en/ld_addr/ld_data    word-write load port, independent of the FSM
//   fetch_cnt                number of completed response handshakes (wraps)
module ysyx_23060096_imem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE       = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [31:0]           fetch_cnt
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT    = 33'(1) << (DEPTH_LOG2 + 2);
  localparam logic [2:0]  CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic [31:0]             addr_q;
  logic [31:0]             mem [0:DEPTH-1];

  logic                    accept;
  logic                    enter_resp;
  logic                    rsp_fire;
  logic [31:0]             samp_addr;
  logic [31:0]             off;
  logic                    samp_err;
  logic [DEPTH_LOG2-1:0]   samp_idx;

  assign accept   = req_valid && (state == IDLE);
  assign rsp_fire = rsp_ready && (state == RESP);

  // With LATENCY == 1 the sampling edge is the acceptance edge, so addr_q is
  // not yet loaded and the live request address must be used instead.
  assign samp_addr  = (state == IDLE) ? req_addr : addr_q;
  assign off        = samp_addr - BASE;
  assign samp_err   = (samp_addr[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
  assign samp_idx   = off[DEPTH_LOG2+1:2];
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; cnt counts remaining WAIT cycles down to zero
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode state only
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, response sampling and handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= 32'h0;
      rsp_inst  <= 32'h0;
      rsp_err   <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      if (accept) addr_q <= req_addr;
      if (enter_resp) begin
        rsp_inst <= samp_err ? 32'h0 : mem[samp_idx];
        rsp_err  <= samp_err;
      end
      if (rsp_fire) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Storage array, not reset; nonblocking write gives read-before-write
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_ysyx_23060096_imem.sv
module tb_ysyx_23060096_imem;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_ready = 1'b0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = 10'h0;
  logic [31:0] ld_data = 32'h0;
  bit          sel = 1'b0;

  logic        rr1, rv1, re1, rr4, rv4, re4;
  logic [31:0] ri1, fc1, ri4, fc4;
  logic        rr, rv, re;
  logic [31:0] ri, fc;

  logic [31:0] mem_m [0:1023];
  bit          loaded_m [0:1023];
  int          loaded_q [$];
  logic [31:0] cnt_m [0:1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060096_imem #(.DEPTH_LOG2(10), .LATENCY(1), .BASE(BASE)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr1),
    .req_addr(req_addr), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_inst(ri1),
    .rsp_err(re1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_cnt(fc1));

  ysyx_23060096_imem #(.DEPTH_LOG2(10), .LATENCY(4), .BASE(BASE)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr4),
    .req_addr(req_addr), .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_inst(ri4),
    .rsp_err(re4), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_cnt(fc4));

  assign rr = sel ? rr4 : rr1;
  assign rv = sel ? rv4 : rv1;
  assign ri = sel ? ri4 : ri1;
  assign re = sel ? re4 : re1;
  assign fc = sel ? fc4 : fc1;

  task automatic load(input int idx, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'(idx); ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    mem_m[idx] = data;
    if (!loaded_m[idx]) begin
      loaded_m[idx] = 1'b1;
      loaded_q.push_back(idx);
    end
  endtask

  // Full fetch transaction on the selected responder. With coll set, d1 is
  // written to the fetched word on the sampling edge and d2 during RESP.
  task automatic do_fetch(input logic [31:0] addr, input int stall, input bit coll,
                          input logic [31:0] d1, input logic [31:0] d2);
    int          lat;
    logic [31:0] off, ei;
    logic        ee;
    int          ix;
    lat = sel ? 4 : 1;
    off = addr - BASE;
    ee  = (addr % 4 != 0) || (off >= 32'd4096);
    ix  = int'(off / 4) % 1024;
    ei  = ee ? 32'h0 : mem_m[ix];
    @(negedge clk);
    if (rr !== 1'b1) begin bad++; $display("FAIL idle_ready addr=%h got=%b want=1", addr, rr); end
    total++;
    req_valid = 1'b1; req_addr = addr;
    if (coll && lat == 1) begin ld_en = 1'b1; ld_addr = 10'(ix); ld_data = d1; end
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    if (ld_en) begin ld_en = 1'b0; mem_m[ix] = ld_data; end
    for (int i = 1; i < lat; i++) begin
      if (rv !== 1'b0 || rr !== 1'b0) begin
        bad++; $display("FAIL wait_state addr=%h cyc=%0d valid=%b ready=%b want 0/0", addr, i, rv, rr);
      end
      total++;
      if (coll && i == lat - 1) begin ld_en = 1'b1; ld_addr = 10'(ix); ld_data = d1; end
      @(negedge clk);
      if (ld_en) begin ld_en = 1'b0; mem_m[ix] = ld_data; end
    end
    if (rv !== 1'b1 || ri !== ei || re !== ee) begin
      bad++; $display("FAIL response addr=%h valid=%b inst=%h err=%b want 1/%h/%b", addr, rv, ri, re, ei, ee);
    end
    total++;
    for (int s = 0; s < stall; s++) begin
      if (coll && s == 0) begin ld_en = 1'b1; ld_addr = 10'(ix); ld_data = d2; end
      @(negedge clk);
      if (ld_en) begin ld_en = 1'b0; mem_m[ix] = ld_data; end
      if (rv !== 1'b1 || ri !== ei || re !== ee || rr !== 1'b0) begin
        bad++; $display("FAIL backpressure addr=%h cyc=%0d valid=%b inst=%h err=%b ready=%b want 1/%h/%b/0",
                        addr, s, rv, ri, re, rr, ei, ee);
      end
      total++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cnt_m[sel] = cnt_m[sel] + 32'd1;
    if (rv !== 1'b0 || rr !== 1'b1 || fc !== cnt_m[sel]) begin
      bad++; $display("FAIL handshake addr=%h valid=%b ready=%b cnt=%h want 0/1/%h", addr, rv, rr, fc, cnt_m[sel]);
    end
    total++;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    if (rv1 !== 1'b0 || ri1 !== 32'h0 || re1 !== 1'b0 || fc1 !== 32'h0 || rv4 !== 1'b0 || fc4 !== 32'h0) begin
      bad++; $display("FAIL reset_values rv=%b ri=%h re=%b fc=%h rv4=%b fc4=%h want zeros", rv1, ri1, re1, fc1, rv4, fc4);
    end
    total++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt_m[0] = 32'h0; cnt_m[1] = 32'h0;
    @(negedge clk);
    if (rr1 !== 1'b1 || rr4 !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b/%b want 1/1", rr1, rr4);
    end
    total++;
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    do_fetch(32'h8000_0002, 0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0002;
    @(negedge clk);
    req_valid = 1'b0;
    if (rv1 !== 1'b1) begin bad++; $display("FAIL mid_resp_valid got=%b want 1", rv1); end
    total++;
    #2 rst = 1'b1;
    #1;
    if (rv1 !== 1'b0 || fc1 !== 32'h0 || re1 !== 1'b0) begin
      bad++; $display("FAIL mid_reset valid=%b cnt=%h err=%b want 0/0/0", rv1, fc1, re1);
    end
    total++;
    @(negedge clk);
    rst = 1'b0;
    cnt_m[0] = 32'h0; cnt_m[1] = 32'h0;
    @(negedge clk);
    if (rr1 !== 1'b1 || rv1 !== 1'b0 || fc1 !== 32'h0) begin
      bad++; $display("FAIL after_reset ready=%b valid=%b cnt=%h want 1/0/0", rr1, rv1, fc1);
    end
    total++;
  endtask

  task automatic test_load_fetch;
    sel = 1'b0;
    load(0, 32'h0000_0413);
    load(1, 32'h0010_0073);
    do_fetch(32'h8000_0000, 0, 1'b0, 32'h0, 32'h0);
    do_fetch(32'h8000_0004, 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_backpressure;
    sel = 1'b1;
    load(5, 32'hDEAD_BEEF);
    do_fetch(32'h8000_0014, 5, 1'b0, 32'h0, 32'h0);
    do_fetch(32'h8000_0000, 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_errors;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_fetch(32'h8000_0002, 0, 1'b0, 32'h0, 32'h0);
      do_fetch(32'h8000_1000, 1, 1'b0, 32'h0, 32'h0);
      do_fetch(32'h7FFF_FFFC, 0, 1'b0, 32'h0, 32'h0);
      do_fetch(32'h8000_0FFC, 0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_collision;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      load(7, 32'h1111_0000 + 32'(s));
      do_fetch(32'h8000_001C, 3, 1'b1, 32'h2222_0000 + 32'(s), 32'h3333_0000 + 32'(s));
      do_fetch(32'h8000_001C, 0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) load($urandom_range(0, 1023), $urandom);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int n = 0; n < 15; n++) begin
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      a = BASE + 32'(4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
        else if (r < 8) a = BASE + 32'($urandom_range(0, 4095));
        else            a = $urandom;
        if (a % 4 == 0 && (a - BASE) < 32'd4096 && !loaded_m[int'((a - BASE) / 4)]) a = a | 32'h1;
        if ($urandom_range(0, 2) == 0) load($urandom_range(0, 1023), $urandom);
        do_fetch(a, $urandom_range(0, 3), 1'b0, 32'h0, 32'h0);
      end
    end
  endtask

  task automatic test_wrap;
    sel = 1'b0;
    @(negedge clk);
    force dut1.fetch_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.fetch_cnt;
    cnt_m[0] = 32'hFFFF_FFFF;
    do_fetch(32'h8000_0004, 0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem_m[i] = 32'h0; loaded_m[i] = 1'b0; end
    cnt_m[0] = 32'h0; cnt_m[1] = 32'h0;
    test_reset();
    test_reset_mid();
    test_load_fetch();
    test_backpressure();
    test_errors();
    test_collision();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
